// File: rtl/force_wb_arbiter.sv
`default_nettype none
// ============================================================================
// force_wb_arbiter : buffers per-lane accumulated forces and serializes them
//                    round-robin onto one valid/ready force-cache write port.
// Revision 1.0
// ============================================================================
module force_wb_arbiter #(
    parameter int  DATA_WIDTH        = 32,
    parameter int  PARTICLE_ID_WIDTH = 20,
    parameter int  CELL_ID_WIDTH     = 3,
    parameter int  NUM_ACC           = 7,
    parameter int  LANE_DEPTH        = 2,
    localparam int ID_WIDTH          = 3*CELL_ID_WIDTH + PARTICLE_ID_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_ACC-1:0]                  in_valid,
    input  logic [NUM_ACC-1:0]                  in_start_wb,
    input  logic [NUM_ACC-1:0][ID_WIDTH-1:0]    in_particle_id,
    input  logic [NUM_ACC-1:0][DATA_WIDTH-1:0]  in_force_x,
    input  logic [NUM_ACC-1:0][DATA_WIDTH-1:0]  in_force_y,
    input  logic [NUM_ACC-1:0][DATA_WIDTH-1:0]  in_force_z,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [2:0]                          out_lane,
    output logic [ID_WIDTH-1:0]                 out_particle_id,
    output logic [DATA_WIDTH-1:0]               out_force_x,
    output logic [DATA_WIDTH-1:0]               out_force_y,
    output logic [DATA_WIDTH-1:0]               out_force_z,
    output logic                                wb_busy,
    output logic                                round_done,
    output logic                                overflow_err
);

    localparam int ENTRY_W = ID_WIDTH + 3*DATA_WIDTH;
    localparam int ADDR_W  = $clog2(LANE_DEPTH);
    localparam int CNT_W   = $clog2(LANE_DEPTH) + 1;
    localparam int LANE_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    logic [NUM_ACC-1:0]               w_nonempty;
    logic [NUM_ACC-1:0]               w_push;
    logic [NUM_ACC-1:0]               w_pop;
    logic [NUM_ACC-1:0]               w_drop;
    logic [NUM_ACC-1:0][ENTRY_W-1:0]  w_head;
    logic                             w_load;
    logic                             w_grant_valid;
    logic [LANE_W-1:0]                w_grant_idx;
    logic [LANE_W-1:0]                w_scan;
    logic                             w_busy;

    logic [LANE_W-1:0]                rr_q;
    logic                             out_valid_q;
    logic [LANE_W-1:0]                out_lane_q;
    logic [ENTRY_W-1:0]               out_entry_q;
    logic                             overflow_q;
    logic                             round_done_q;
    state_t                           state_q;

    // Per-lane FIFO; a push into a full lane still lands if that lane pops this cycle.
    for (genvar i = 0; i < NUM_ACC; i++) begin : g_lane
        logic [ENTRY_W-1:0] mem_q [LANE_DEPTH];
        logic [ADDR_W-1:0]  wr_ptr_q;
        logic [ADDR_W-1:0]  rd_ptr_q;
        logic [CNT_W-1:0]   cnt_q;
        logic               w_full;

        assign w_full        = (cnt_q == CNT_W'(LANE_DEPTH));
        assign w_nonempty[i] = (cnt_q != '0);
        assign w_push[i]     = in_valid[i] & (~w_full | w_pop[i]);
        assign w_drop[i]     = in_valid[i] & w_full & ~w_pop[i];
        assign w_head[i]     = mem_q[rd_ptr_q];

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (w_push[i]) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                if (w_pop[i])  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                case ({w_push[i], w_pop[i]})
                    2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                    2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (w_push[i]) begin
                mem_q[wr_ptr_q] <= {in_particle_id[i], in_force_x[i], in_force_y[i], in_force_z[i]};
            end
        end
    end

    assign w_load = ~out_valid_q | out_ready;

    // First non-empty lane after the last grant, wrapping at NUM_ACC.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_scan        = '0;
        for (int k = 1; k <= NUM_ACC; k++) begin
            w_scan = LANE_W'((int'(rr_q) + k) % NUM_ACC);
            if (!w_grant_valid && w_nonempty[w_scan]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_scan;
            end
        end
    end

    assign w_pop  = (w_load && w_grant_valid) ? (NUM_ACC'(1) << w_grant_idx) : '0;
    assign w_busy = (|w_nonempty) | out_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q        <= LANE_W'(NUM_ACC - 1);
            out_valid_q <= 1'b0;
            out_lane_q  <= '0;
            out_entry_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (w_load) begin
                if (w_grant_valid) begin
                    out_valid_q <= 1'b1;
                    out_lane_q  <= w_grant_idx;
                    out_entry_q <= w_head[w_grant_idx];
                    rr_q        <= w_grant_idx;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
            if (|w_drop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            round_done_q <= 1'b0;
        end else begin
            round_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|in_start_wb) state_q <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (!w_busy && (in_valid == '0) && (in_start_wb == '0)) begin
                        state_q      <= S_DONE;
                        round_done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= (|in_start_wb) ? S_ACTIVE : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid       = out_valid_q;
    assign out_lane        = out_lane_q;
    assign out_particle_id = out_entry_q[ENTRY_W-1 -: ID_WIDTH];
    assign out_force_x     = out_entry_q[3*DATA_WIDTH-1 -: DATA_WIDTH];
    assign out_force_y     = out_entry_q[2*DATA_WIDTH-1 -: DATA_WIDTH];
    assign out_force_z     = out_entry_q[DATA_WIDTH-1:0];
    assign wb_busy         = w_busy;
    assign round_done      = round_done_q;
    assign overflow_err    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_force_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_force_wb_arbiter : vector table, directed corner sequences and random
//                       traffic against a queue-based reference model.
// Revision 1.0
// ============================================================================
module tb_force_wb_arbiter;

    localparam int DW  = 32;
    localparam int PIW = 20;
    localparam int CW  = 3;
    localparam int N   = 7;
    localparam int D   = 2;
    localparam int IDW = 3*CW + PIW;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [N-1:0]             in_valid = '0;
    logic [N-1:0]             in_start_wb = '0;
    logic [N-1:0][IDW-1:0]    in_particle_id = '0;
    logic [N-1:0][DW-1:0]     in_force_x = '0;
    logic [N-1:0][DW-1:0]     in_force_y = '0;
    logic [N-1:0][DW-1:0]     in_force_z = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [2:0]               out_lane;
    logic [IDW-1:0]           out_particle_id;
    logic [DW-1:0]            out_force_x;
    logic [DW-1:0]            out_force_y;
    logic [DW-1:0]            out_force_z;
    logic                     wb_busy;
    logic                     round_done;
    logic                     overflow_err;

    always #5 clk = ~clk;

    force_wb_arbiter #(
        .DATA_WIDTH        (DW),
        .PARTICLE_ID_WIDTH (PIW),
        .CELL_ID_WIDTH     (CW),
        .NUM_ACC           (N),
        .LANE_DEPTH        (D)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_start_wb     (in_start_wb),
        .in_particle_id  (in_particle_id),
        .in_force_x      (in_force_x),
        .in_force_y      (in_force_y),
        .in_force_z      (in_force_z),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_lane        (out_lane),
        .out_particle_id (out_particle_id),
        .out_force_x     (out_force_x),
        .out_force_y     (out_force_y),
        .out_force_z     (out_force_z),
        .wb_busy         (wb_busy),
        .round_done      (round_done),
        .overflow_err    (overflow_err)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  x;
        logic [DW-1:0]  y;
        logic [DW-1:0]  z;
    } ent_t;

    typedef struct {
        bit           r;
        logic [N-1:0] v;
        logic [N-1:0] s;
        bit           rdy;
        bit           eov;
        int           elane;
        bit           ebusy;
        bit           edone;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Reference model: lane queues, one output slot, last-granted lane, round phase.
    ent_t mq [N][$];
    bit   m_ov;
    int   m_lane;
    ent_t m_out;
    int   m_ptr;
    bit   m_ovf;
    int   m_phase;   // 0 idle, 1 round open, 2 round just finished

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit m_busy();
        bit b = m_ov;
        for (int i = 0; i < N; i++) if (mq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_ov = 1'b0; m_lane = 0; m_out = '0; m_ptr = N-1; m_ovf = 1'b0; m_phase = 0;
    endfunction

    function automatic void model_check();
        chk("out_valid", out_valid, m_ov);
        chk("wb_busy", wb_busy, m_busy());
        chk("round_done", round_done, m_phase == 2);
        chk("overflow_err", overflow_err, m_ovf);
        if (m_ov) begin
            chk("out_lane", out_lane, m_lane);
            chk("out_particle_id", out_particle_id, m_out.id);
            chk("out_force_x", out_force_x, m_out.x);
            chk("out_force_y", out_force_y, m_out.y);
            chk("out_force_z", out_force_z, m_out.z);
        end
    endfunction

    function automatic void model_step();
        bit was_busy;
        bit found;
        int l;
        if (rst) begin
            model_reset();
            return;
        end
        was_busy = m_busy();
        if (!m_ov || out_ready) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                l = (m_ptr + k) % N;
                if (!found && mq[l].size() > 0) begin
                    found  = 1'b1;
                    m_out  = mq[l].pop_front();
                    m_lane = l;
                    m_ptr  = l;
                end
            end
            m_ov = found;
        end
        for (int i = 0; i < N; i++) begin
            if (in_valid[i]) begin
                if (mq[i].size() < D)
                    mq[i].push_back({in_particle_id[i], in_force_x[i], in_force_y[i], in_force_z[i]});
                else
                    m_ovf = 1'b1;
            end
        end
        case (m_phase)
            0: if (in_start_wb != 0) m_phase = 1;
            1: if (!was_busy && in_valid == 0 && in_start_wb == 0) m_phase = 2;
            default: m_phase = (in_start_wb != 0) ? 1 : 0;
        endcase
    endfunction

    task automatic half();
        @(negedge clk);
        model_check();
    endtask

    task automatic fin();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        half();
        fin();
    endtask

    task automatic rand_pay();
        for (int i = 0; i < N; i++) begin
            in_particle_id[i] = IDW'($urandom);
            in_force_x[i]     = $urandom;
            in_force_y[i]     = $urandom;
            in_force_z[i]     = $urandom;
        end
    endtask

    task automatic push_lane(input int lane, input ent_t e);
        in_particle_id[lane] = e.id;
        in_force_x[lane]     = e.x;
        in_force_y[lane]     = e.y;
        in_force_z[lane]     = e.z;
        in_valid             = N'(1) << lane;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = '0; in_start_wb = '0;
        tick();
        rst = 1'b0;
    endtask

    vec_t tq[$];

    task automatic add(input bit r, input logic [N-1:0] v, input logic [N-1:0] s,
                       input bit eov, input int elane, input bit ebusy, input bit edone);
        tq.push_back('{r, v, s, 1'b1, eov, elane, ebusy, edone});
    endtask

    initial begin
        ent_t e [3];
        ent_t got [$];

        // Single entry on lane 3, then reset, all-lane burst, then a round.
        add(0, 7'h08, 7'h00, 0, 0, 0, 0);
        add(0, 7'h00, 7'h00, 0, 0, 1, 0);
        add(0, 7'h00, 7'h00, 1, 3, 1, 0);
        add(0, 7'h00, 7'h00, 0, 0, 0, 0);
        add(0, 7'h00, 7'h00, 0, 0, 0, 0);
        add(1, 7'h00, 7'h00, 0, 0, 0, 0);
        add(0, 7'h7F, 7'h00, 0, 0, 0, 0);
        add(0, 7'h00, 7'h00, 0, 0, 1, 0);
        for (int k = 0; k < N; k++) add(0, 7'h00, 7'h00, 1, k, 1, 0);
        add(0, 7'h00, 7'h00, 0, 0, 0, 0);
        add(0, 7'h0F, 7'h01, 0, 0, 0, 0);
        add(0, 7'h00, 7'h00, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) add(0, 7'h00, 7'h00, 1, k, 1, 0);
        add(0, 7'h00, 7'h00, 0, 0, 0, 0);
        add(0, 7'h00, 7'h00, 0, 0, 0, 1);
        add(0, 7'h00, 7'h00, 0, 0, 0, 0);

        rst = 1'b1;
        rand_pay();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        half();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_lane", out_lane, 0);
        chk("rst_out_id", out_particle_id, 0);
        chk("rst_out_x", out_force_x, 0);
        chk("rst_out_y", out_force_y, 0);
        chk("rst_out_z", out_force_z, 0);
        chk("rst_wb_busy", wb_busy, 0);
        chk("rst_round_done", round_done, 0);
        chk("rst_overflow", overflow_err, 0);
        fin();
        rst = 1'b0;

        foreach (tq[k]) begin
            rand_pay();
            if (k == 0) begin
                in_particle_id[3] = 29'h1A500042;
                in_force_x[3]     = 32'h3F800000;
            end
            rst = tq[k].r; in_valid = tq[k].v; in_start_wb = tq[k].s; out_ready = tq[k].rdy;
            half();
            chk("tbl_out_valid", out_valid, tq[k].eov);
            chk("tbl_wb_busy", wb_busy, tq[k].ebusy);
            chk("tbl_round_done", round_done, tq[k].edone);
            if (tq[k].eov) chk("tbl_out_lane", out_lane, tq[k].elane);
            if (k == 2) begin
                chk("tbl_single_id", out_particle_id, 29'h1A500042);
                chk("tbl_single_x", out_force_x, 32'h3F800000);
            end
            fin();
        end
        rst = 1'b0; in_valid = '0; in_start_wb = '0;

        // Backpressure: lane 2 held for five cycles while two more entries queue up.
        do_reset();
        e[0] = '{29'h0A000001, 32'h11111111, 32'h22222222, 32'h33333333};
        e[1] = '{29'h0A000002, 32'h44444444, 32'h55555555, 32'h66666666};
        e[2] = '{29'h0A000003, 32'h77777777, 32'h88888888, 32'h99999999};
        out_ready = 1'b1;
        push_lane(2, e[0]);
        tick();
        in_valid = '0;
        tick();
        out_ready = 1'b0;
        for (int h = 0; h < 5; h++) begin
            if (h == 1) push_lane(2, e[1]);
            else if (h == 3) push_lane(2, e[2]);
            else in_valid = '0;
            half();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_lane", out_lane, 2);
            chk("bp_hold_id", out_particle_id, e[0].id);
            chk("bp_hold_x", out_force_x, e[0].x);
            fin();
        end
        in_valid = '0;
        out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 12; c++) begin
            half();
            if (out_valid) got.push_back('{out_particle_id, out_force_x, out_force_y, out_force_z});
            fin();
        end
        chk("bp_count", got.size(), 3);
        for (int j = 0; j < 3 && j < got.size(); j++) begin
            chk("bp_order_id", got[j].id, e[j].id);
            chk("bp_order_z", got[j].z, e[j].z);
        end

        // Overflow: fourth push into lane 5 with the sink stalled is dropped.
        do_reset();
        out_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            push_lane(5, '{IDW'(29'h05000010 + p), 32'(p), 32'(p + 10), 32'(p + 20)});
            tick();
        end
        push_lane(5, '{29'h05000013, 32'hDEAD0003, 32'h0, 32'h0});
        half();
        chk("ovf_before_drop", overflow_err, 0);
        fin();
        in_valid = '0;
        for (int c = 0; c < 3; c++) begin
            half();
            chk("ovf_sticky", overflow_err, 1);
            fin();
        end
        out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 8; c++) begin
            half();
            if (out_valid) got.push_back('{out_particle_id, out_force_x, out_force_y, out_force_z});
            fin();
        end
        chk("ovf_delivered", got.size(), 3);
        for (int j = 0; j < 3 && j < got.size(); j++) chk("ovf_order", got[j].id, 29'h05000010 + j);
        half();
        chk("ovf_after_drain", overflow_err, 1);
        fin();

        // Reset mid-drain with a round open; lane 0 wins first afterwards.
        do_reset();
        out_ready = 1'b0;
        rand_pay();
        in_start_wb = 7'h01; in_valid = 7'h07;
        tick();
        in_start_wb = '0; in_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        half();
        chk("rmd_out_valid", out_valid, 0);
        chk("rmd_wb_busy", wb_busy, 0);
        fin();
        out_ready = 1'b1;
        rand_pay();
        in_valid = 7'h41;
        tick();
        in_valid = '0;
        tick();
        half();
        chk("rmd_first_lane", out_lane, 0);
        fin();
        half();
        chk("rmd_second_lane", out_lane, 6);
        fin();
        for (int c = 0; c < 5; c++) begin
            half();
            chk("rmd_no_round", round_done, 0);
            fin();
        end

        // Random traffic against the model.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rand_pay();
            for (int i = 0; i < N; i++) in_valid[i] = ($urandom_range(0, 9) < 3);
            in_start_wb = ($urandom_range(0, 15) == 0) ? (N'(1) << $urandom_range(0, N-1)) : '0;
            if ((cyc % 200) < 40) out_ready = ($urandom_range(0, 4) == 0);
            else                  out_ready = ($urandom_range(0, 3) != 0);
            if ((cyc % 250) > 230) in_valid = '0;
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0; in_valid = '0; in_start_wb = '0; out_ready = 1'b1;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
